// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the unified memory port between the CPU control unit and a boot/debug loader.
// Define MEM_LOADER_EN to enable the loader port and the round-robin tie-break; otherwise the CPU is the sole requester.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [1:0]  Type,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        M_busy,
    output logic [1:0]  M_Wrong,
    input  logic        L_req,
    input  logic        L_we,
    input  logic [31:0] L_addr,
    input  logic [31:0] L_wdata,
    output logic        L_grant,
    output logic        L_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        own_ld, we_q, grant_q;
    logic [1:0]  type_q, lane_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        idle, cpu_req, ill, mis, cpu_v, cpu_win, ld_win;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wd, sh, rd_next;
    logic        unused_l;

    assign idle    = RSTn && state == IDLE;
    assign cpu_req = MemRd | MemWr;
    assign ill     = Type == 2'b11;
    assign mis     = (Type == 2'b01 && Addr[0]) || (Type == 2'b00 && Addr[1:0] != 2'b00);
    assign cpu_v   = cpu_req && !ill && !mis;
    assign M_Wrong = (idle && cpu_req) ? (ill ? 2'b10 : mis ? 2'b01 : 2'b00) : 2'b00;

`ifdef MEM_LOADER_EN
    logic last_ld;
    assign cpu_win  = idle && cpu_v && (!L_req || last_ld);
    assign ld_win   = idle && L_req && !cpu_win;
    assign unused_l = &{1'b0, L_addr[1:0]};
`else
    assign cpu_win  = idle && cpu_v;
    assign ld_win   = 1'b0;
    assign unused_l = &{1'b0, L_req, L_addr[1:0]};
`endif

    assign cpu_be = Type == 2'b00 ? 4'hF :
                    Type == 2'b01 ? (Addr[1] ? 4'hC : 4'h3) :
                    4'b0001 << Addr[1:0];
    assign cpu_wd = Type == 2'b00 ? WData :
                    Type == 2'b01 ? {2{WData[15:0]}} :
                    {4{WData[7:0]}};

    // Read lane is shifted down by the latched byte offset, then masked to the access width.
    assign sh      = mem_rdata >> {lane_q, 3'b000};
    assign rd_next = type_q == 2'b10 ? {24'b0, sh[7:0]} :
                     type_q == 2'b01 ? {16'b0, sh[15:0]} : sh;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            own_ld  <= 1'b0;
            we_q    <= 1'b0;
            grant_q <= 1'b0;
            type_q  <= 2'b00;
            lane_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            RData   <= '0;
`ifdef MEM_LOADER_EN
            last_ld <= 1'b1;
`endif
        end else begin
            grant_q <= 1'b0;
            case (state)
                IDLE: if (cpu_win || ld_win) begin
                    state   <= ACCESS;
                    cnt     <= '0;
                    own_ld  <= ld_win;
                    grant_q <= ld_win;
                    addr_q  <= ld_win ? L_addr[31:2] : Addr[31:2];
                    be_q    <= ld_win ? 4'hF : cpu_be;
                    wdata_q <= ld_win ? L_wdata : cpu_wd;
                    we_q    <= ld_win ? L_we : MemWr;
                    type_q  <= ld_win ? 2'b00 : Type;
                    lane_q  <= ld_win ? 2'b00 : Addr[1:0];
`ifdef MEM_LOADER_EN
                    last_ld <= ld_win;
`endif
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(WAIT_CYCLES - 1)) begin
                        state <= DONE;
                        if (!we_q) RData <= rd_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_en    = state == ACCESS;
    assign mem_we    = mem_en && we_q;
    assign mem_be    = mem_en ? be_q : 4'h0;
    assign mem_addr  = mem_en ? addr_q : 30'h0;
    assign mem_wdata = mem_en ? wdata_q : 32'h0;
    assign M_busy    = cpu_win || (mem_en && !own_ld);
    assign L_grant   = grant_q;
    assign L_done    = state == DONE && own_ld;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences every access to the single unified instruction/data memory port and shares that port between the CPU control unit and a boot/debug loader. It accepts the CU's MemRd/MemWr/Type/address, drives the memory with a fixed number of wait cycles and returns lane-aligned read data. It generates the `M_busy` stall and the two-bit `M_Wrong` fault code that the CU samples. It sits between the CU/datapath (address and MDR side) and the memory macro.

## Interface
- `WAIT_CYCLES`, 2: cycles `mem_en` stays high per access (1..15).
- `CLK`  in  1  system clock, rising edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `MemRd`, `MemWr`  in  1  CPU read/write request, level, held until `M_busy` falls.
- `Type`  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
- `Addr`  in  32  CPU byte address.
- `WData`  in  32  CPU write data, right-justified.
- `RData`  out  32  registered read data, zero-extended lane (sign-extension is done by the datapath).
- `M_busy`  out  1  CPU access in progress.
- `M_Wrong`  out  2  fault pulse: 01 misaligned, 10 illegal Type.
- `L_req`, `L_we`  in  1  loader request (level) and write select.
- `L_addr`, `L_wdata`  in  32  loader word address (bits [1:0] ignored) and data.
- `L_grant`, `L_done`  out  1  one-cycle pulses: request accepted / access complete.
- `mem_en`, `mem_we`  out  1  memory strobe and write enable.
- `mem_be`  out  4  byte enables; bit n = byte lane n, little-endian.
- `mem_addr`  out  30  word address.
- `mem_wdata`  out  32  lane-replicated write data.
- `mem_rdata`  in  32  memory read data, valid in the last ACCESS cycle.

## Operation
- FSM: IDLE → ACCESS → DONE → IDLE. Owner register `last` records who was granted last; reset value LOADER, so the CPU wins the first tie.
- IDLE: CPU request = `MemRd|MemWr` (both high counts as a write). A CPU request that is misaligned (half with Addr[0]=1, word with Addr[1:0]≠0) or has Type=11 is not issued. `M_Wrong` pulses for 1 cycle with code 01 or 10; Type=11 has priority. The FSM stays in IDLE.
- Arbitration in IDLE: if only one requester is valid it wins. If both are valid, the one ≠ `last` wins. A faulting CPU request never takes the grant, so the loader may be served in the same cycle.
- On acceptance, latch owner, address, byte enables, write data and direction, then go to ACCESS. For a loader grant, `L_grant` pulses.
- ACCESS: `mem_en`=1 and a counter runs 0..WAIT_CYCLES-1. On the last count a read captures `mem_rdata` into `RData` (lane-shifted and masked per Type), then go to DONE.
- Byte enables: word 1111; half 0011 or 1100 per Addr[1]; byte one-hot of Addr[1:0]. Write data is replicated: half as {h,h}, byte as {b,b,b,b}. Loader accesses are always word.
- DONE: single cycle, `M_busy`=0. `L_done` pulses if the owner is the loader. Always returns to IDLE; requests are not accepted in DONE.
- `M_busy` = (CPU request valid and granted in IDLE) | (state≠IDLE and owner=CPU and state≠DONE). It is combinational in IDLE so the CU stalls in the same cycle.
- Loader reads also update `RData`.
- Reset values: state IDLE, `last`=LOADER, `RData`=0. All outputs are 0: `M_busy`, `M_Wrong`, `L_grant`, `L_done`, `mem_en`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`.

## Timing
- Access latency from acceptance edge: WAIT_CYCLES (ACCESS) + 1 (DONE). With the default this is 3 cycles, of which `M_busy` is high for 2 edges after acceptance plus the acceptance cycle.
- `RData` is valid from the DONE cycle and holds until the next read completes.
- `M_Wrong` is high exactly one cycle for each cycle a faulting request is present in IDLE. The CU must drop the request after sampling it.
- Reset asserted mid-access: `mem_en` drops immediately and the access is abandoned with no `L_done`.
- `L_req` dropped during ACCESS has no effect; the access completes.

## Configuration
- `MEM_LOADER_EN` defined: the loader port and arbitration are as above.
- Undefined: the L_* inputs are ignored, `L_grant`/`L_done`/`L_rdata` paths are tied 0, `last` logic is removed, and the CPU is the only requester. Timing is otherwise identical.

## Test plan
- Word read: Addr=0x100, Type=00, mem_rdata=0xDEADBEEF → `mem_be`=1111, `mem_addr`=0x40, `M_busy` for 3 cycles, `RData`=0xDEADBEEF in DONE.
- Byte write: Addr=0x103, Type=10, WData=0x5A → `mem_be`=1000, `mem_wdata`=0x5A5A5A5A, `mem_we`=1 for 2 cycles.
- Faults: Type=01 with Addr=0x101 → `M_Wrong`=01 for 1 cycle, no `mem_en`. Type=11 with Addr=0x101 → `M_Wrong`=10.
- Tie: CPU and loader both request from reset → CPU first. On the next tie the loader is granted (`L_grant` pulse) and `L_done` follows 2 cycles later.
- `RSTn` low during the 2nd ACCESS cycle → `mem_en`=0 immediately, all outputs at reset values, FSM in IDLE after release.
- Without `MEM_LOADER_EN`: `L_req`=1 continuously → `L_grant` never asserts and CPU accesses are unaffected.
